// File: rtl/core_pkg.sv
// Shared types for the core pipeline: default datapath widths, the MEM/WB payload
// layout, and the occupancy-state encoding used by the elastic pipeline registers.
package core_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 4;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_read_value;
    logic [DEST_W-1:0] dest;
  } mem_wb_payload_t;

  // The encoding equals the number of held entries, so the state drives occupancy directly.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_buffer.sv
// Generic valid/ready register stage with a one-entry skid.
// Upstream ready depends only on registered state; flush clears both entries.
module skid_buffer
  import core_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [1:0]           occupancy_o
);

  // state      | meaning
  // SKID_EMPTY | no entry held
  // SKID_ONE   | main entry valid, skid empty
  // SKID_TWO   | main and skid entries valid, upstream stalled

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, skid_q;
  logic                 accept, consume;
  logic                 load_main_in, load_main_skid, load_skid;

  assign in_ready_o    = (state_q != SKID_TWO);
  assign out_valid_o   = (state_q != SKID_EMPTY);
  assign out_payload_o = main_q;
  assign occupancy_o   = state_q;

  assign accept  = in_valid_i & in_ready_o & ~flush_i;
  assign consume = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SKID_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (consume && accept) begin
            load_main_in = 1'b1;
          end else if (consume) begin
            state_d = SKID_EMPTY;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = SKID_TWO;
          end
        end
        SKID_TWO: begin
          // in_ready is low here, so the only possible event is a consume.
          if (consume) begin
            load_main_skid = 1'b1;
            state_d        = SKID_ONE;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
        end
      endcase
    end
  end

  // Payloads hold through a flush; only the state marks them invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_payload_i;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_payload_i;
      end
    end
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// Elastic MEM->WB pipeline register: packs the MEM payload into a skid buffer,
// gates the write enables with the head valid and selects the write-back value.
module mem_wb_skid_reg #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int DEST_W = core_pkg::DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_read_value_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] wb_value,
  output logic [1:0]        occupancy
);

  // Same field order as core_pkg::mem_wb_payload_t, but sized by this instance's parameters.
  localparam int PAYLOAD_W = 2 + 2 * DATA_W + DEST_W;

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] head_payload;
  logic                 head_wb_en;
  logic                 head_mem_r_en;

  assign in_payload = {wb_en_in, mem_r_en_in, alu_result_in, mem_read_value_in, dest_in};

  skid_buffer #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_payload_i  (in_payload),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_payload_o (head_payload),
    .occupancy_o   (occupancy)
  );

  assign {head_wb_en, head_mem_r_en, alu_result, mem_read_value, dest} = head_payload;

  // A stale payload left behind by a flush must never reach the register file.
  assign wb_en    = head_wb_en & out_valid;
  assign mem_r_en = head_mem_r_en & out_valid;
  assign wb_value = head_mem_r_en ? mem_read_value : alu_result;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Scoreboard bench for mem_wb_skid_reg: directed stimulus pushes expected entries,
// a negedge monitor tracks occupancy with its own model and checks every delivered entry.
module tb_mem_wb_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic [31:0] alu_result_in;
  logic [31:0] mem_read_value_in;
  logic [3:0]  dest_in;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic        mem_r_en;
  logic [31:0] alu_result;
  logic [31:0] mem_read_value;
  logic [3:0]  dest;
  logic [31:0] wb_value;
  logic [1:0]  occupancy;

  logic        w_flush;
  logic        w_in_valid;
  logic        w_in_ready;
  logic        w_wb_en_in;
  logic        w_mem_r_en_in;
  logic [63:0] w_alu_result_in;
  logic [63:0] w_mem_read_value_in;
  logic [4:0]  w_dest_in;
  logic        w_out_valid;
  logic        w_out_ready;
  logic        w_wb_en;
  logic        w_mem_r_en;
  logic [63:0] w_alu_result;
  logic [63:0] w_mem_read_value;
  logic [4:0]  w_dest;
  logic [63:0] w_wb_value;
  logic [1:0]  w_occupancy;

  mem_wb_skid_reg dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .wb_en_in          (wb_en_in),
    .mem_r_en_in       (mem_r_en_in),
    .alu_result_in     (alu_result_in),
    .mem_read_value_in (mem_read_value_in),
    .dest_in           (dest_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .wb_en             (wb_en),
    .mem_r_en          (mem_r_en),
    .alu_result        (alu_result),
    .mem_read_value    (mem_read_value),
    .dest              (dest),
    .wb_value          (wb_value),
    .occupancy         (occupancy)
  );

  mem_wb_skid_reg #(
    .DATA_W (64),
    .DEST_W (5)
  ) dut_wide (
    .clk               (clk),
    .rst               (rst),
    .flush             (w_flush),
    .in_valid          (w_in_valid),
    .in_ready          (w_in_ready),
    .wb_en_in          (w_wb_en_in),
    .mem_r_en_in       (w_mem_r_en_in),
    .alu_result_in     (w_alu_result_in),
    .mem_read_value_in (w_mem_read_value_in),
    .dest_in           (w_dest_in),
    .out_valid         (w_out_valid),
    .out_ready         (w_out_ready),
    .wb_en             (w_wb_en),
    .mem_r_en          (w_mem_r_en),
    .alu_result        (w_alu_result),
    .mem_read_value    (w_mem_read_value),
    .dest              (w_dest),
    .wb_value          (w_wb_value),
    .occupancy         (w_occupancy)
  );

  typedef struct {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] mrv;
    logic [3:0]  dest;
    logic [31:0] wbv;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_occ = 0;
  bit   last_acc = 0;
  int   mon_cons, mon_acc;
  exp_t mon_e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares against the bench's own occupancy model and expected-entry queue.
  always @(negedge clk) begin
    if (rst) begin
      model_occ = 0;
      sb_q.delete();
      last_acc  = 1'b0;
    end else begin
      check("occupancy", {62'd0, occupancy}, model_occ);
      check("in_ready", in_ready, model_occ != 2);
      check("out_valid", out_valid, model_occ != 0);
      if (model_occ == 0) begin
        check("wb_en_idle", wb_en, 1'b0);
        check("mem_r_en_idle", mem_r_en, 1'b0);
      end
      mon_cons = (model_occ != 0 && out_ready) ? 1 : 0;
      mon_acc  = (in_valid && model_occ != 2 && !flush) ? 1 : 0;
      if (mon_cons != 0) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_wb_en", wb_en, mon_e.wb_en);
          check("out_mem_r_en", mem_r_en, mon_e.mem_r_en);
          check("out_alu_result", alu_result, mon_e.alu);
          check("out_mem_read_value", mem_read_value, mon_e.mrv);
          check("out_dest", dest, mon_e.dest);
          check("out_wb_value", wb_value, mon_e.wbv);
        end
      end
      if (mon_acc != 0) begin
        mon_e.wb_en    = wb_en_in;
        mon_e.mem_r_en = mem_r_en_in;
        mon_e.alu      = alu_result_in;
        mon_e.mrv      = mem_read_value_in;
        mon_e.dest     = dest_in;
        mon_e.wbv      = mem_r_en_in ? mem_read_value_in : alu_result_in;
        sb_q.push_back(mon_e);
      end
      last_acc = (mon_acc != 0);
      if (flush) begin
        model_occ = 0;
        sb_q.delete();
      end else begin
        model_occ = model_occ + mon_acc - mon_cons;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input bit mr, input logic [31:0] alu,
                       input logic [31:0] mrv, input logic [3:0] d);
    in_valid          = v;
    wb_en_in          = we;
    mem_r_en_in       = mr;
    alu_result_in     = alu;
    mem_read_value_in = mrv;
    dest_in           = d;
  endtask

  task automatic send(input bit we, input bit mr, input logic [31:0] alu,
                      input logic [31:0] mrv, input logic [3:0] d, input int maxc);
    bit done;
    done = 1'b0;
    drive(1'b1, we, mr, alu, mrv, d);
    for (int c = 0; c < maxc && !done; c++) begin
      tick();
      done = last_acc;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    w_flush = 1'b0;
    w_in_valid = 1'b0;
    w_out_ready = 1'b1;
    w_wb_en_in = 1'b0;
    w_mem_r_en_in = 1'b0;
    w_alu_result_in = '0;
    w_mem_read_value_in = '0;
    w_dest_in = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_occupancy", {62'd0, occupancy}, 0);
    check("rst_wb_value", wb_value, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Streaming at full rate, alternating ALU and load results.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, i[0], 32'h100 + i, 32'hA000 + i, 4'(i), 10);
    end
    idle(3);

    // Backpressure: A held, B skidded, C blocked until drain.
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'h0000_000A, 32'h0000_001A, 4'd3, 10);
    send(1'b1, 1'b0, 32'h0000_000B, 32'h0000_001B, 4'd5, 10);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_000C, 32'h0000_001C, 4'd7);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("c_blocked", last_acc, 1'b0);
      check("a_held_dest", dest, 4'd3);
      check("a_held_alu", alu_result, 32'h0000_000A);
      check("bp_occupancy", {62'd0, occupancy}, 2);
    end
    out_ready = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        tick();
        got = last_acc;
      end
      check("c_accepted", got, 1'b1);
    end
    idle(4);

    // Flush at full occupancy with a competing input.
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'h0000_00D0, 32'h0, 4'd1, 10);
    send(1'b1, 1'b0, 32'h0000_00E0, 32'h0, 4'd2, 10);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_00F0, 32'h0, 4'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_wb_en", wb_en, 1'b0);
    check("flush_occupancy", {62'd0, occupancy}, 0);
    out_ready = 1'b1;
    idle(3);

    // Flush with simultaneous consume and a discarded accept.
    send(1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'd6, 10);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 4'd8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush2_occupancy", {62'd0, occupancy}, 0);
    idle(3);

    // Load selects the memory value; write enable without valid never reaches WB.
    send(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'd9, 10);
    check("load_wb_value", wb_value, 32'hDEAD_BEEF);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'd10);
    tick();
    check("novalid_wb_en", wb_en, 1'b0);
    tick();

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    send(1'b1, 1'b0, 32'h0000_0111, 32'h0, 4'd11, 10);
    send(1'b1, 1'b1, 32'h0000_0222, 32'h0000_0333, 4'd12, 10);
    in_valid = 1'b0;
    check("pre_rst_occupancy", {62'd0, occupancy}, 2);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_wb_en", wb_en, 1'b0);
    check("midrst_mem_r_en", mem_r_en, 1'b0);
    check("midrst_alu_result", alu_result, 32'd0);
    check("midrst_mem_read_value", mem_read_value, 32'd0);
    check("midrst_dest", dest, 4'd0);
    check("midrst_wb_value", wb_value, 32'd0);
    check("midrst_occupancy", {62'd0, occupancy}, 0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Wide instance carries full-width values unchanged.
    w_in_valid = 1'b1;
    w_wb_en_in = 1'b1;
    w_mem_r_en_in = 1'b1;
    w_alu_result_in = 64'hFEDC_BA98_7654_3210;
    w_mem_read_value_in = 64'h0123_4567_89AB_CDEF;
    w_dest_in = 5'd31;
    tick();
    w_in_valid = 1'b0;
    check("wide_out_valid", w_out_valid, 1'b1);
    check("wide_alu_result", w_alu_result, 64'hFEDC_BA98_7654_3210);
    check("wide_mem_read_value", w_mem_read_value, 64'h0123_4567_89AB_CDEF);
    check("wide_dest", {59'd0, w_dest}, 31);
    check("wide_wb_value", w_wb_value, 64'h0123_4567_89AB_CDEF);
    check("wide_wb_en", w_wb_en, 1'b1);
    tick();
    check("wide_drained", w_out_valid, 1'b0);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised, elastic MEM→WB pipeline register for the 5-stage ARM core. It replaces the fixed always-load MEM/WB register with a valid/ready stage plus a one-entry skid buffer, so the write-back side can stall without a combinational ready path back into MEM. It also supports squashing in-flight entries and produces the selected write-back value. It sits between the memory stage and the register-file write port.

## Interface
Parameters:
- DATA_W, 32, width of ALU result, memory read value and write-back value
- DEST_W, 4, width of destination register index

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  stage can accept an entry this cycle
- wb_en_in  in  1  entry writes the register file
- mem_r_en_in  in  1  entry is a load
- alu_result_in  in  DATA_W  ALU result
- mem_read_value_in  in  DATA_W  data-memory read value
- dest_in  in  DEST_W  destination register index
- out_valid  out  1  head entry valid
- out_ready  in  1  WB consumes the head entry this cycle
- wb_en  out  1  head wb_en AND out_valid
- mem_r_en  out  1  head mem_r_en AND out_valid
- alu_result  out  DATA_W  head ALU result
- mem_read_value  out  DATA_W  head read value
- dest  out  DEST_W  head destination index
- wb_value  out  DATA_W  mem_r_en ? mem_read_value : alu_result, from head
- occupancy  out  2  entries held (0, 1 or 2)

## Operation
- Storage: main entry (drives outputs) and skid entry. Each has a valid bit and a payload {wb_en, mem_r_en, alu_result, mem_read_value, dest}.
- Accept: in_valid & in_ready & ~flush.
- Consume: out_valid & out_ready.
- in_ready = ~skid_valid. It is a registered-state function only, with no combinational path from out_ready.
- out_valid = main_valid.
- Per-cycle update, when not flushing:
  - Main empty, accept → load main.
  - Main full, consume, skid full → skid moves to main, skid empties. A simultaneous accept is impossible because in_ready=0.
  - Main full, consume, skid empty, accept → load main from input.
  - Main full, consume, no accept → main empties.
  - Main full, no consume, accept → load skid.
  - Otherwise hold.
- Order is strictly FIFO: an entry never overtakes an older one.
- Flush has priority over everything: both valid bits clear at the next edge, and an accept in the flush cycle is discarded. Payload registers hold their old values.
- wb_en and mem_r_en outputs are gated by out_valid, so an empty or flushed stage never writes the register file.
- wb_value is combinational from main payload; no arithmetic is performed.

## Timing
- Reset, asynchronous:
  - All valid bits and payloads go to 0.
  - Outputs: out_valid=0, wb_en=0, mem_r_en=0, alu_result=0, mem_read_value=0, dest=0, wb_value=0, occupancy=0.
  - in_ready=1 during and after reset.
- Latency: an entry accepted at edge N is visible on outputs after edge N, with out_valid=1 from cycle N+1.
- Throughput: 1 entry/cycle with out_ready held high. Occupancy then never exceeds 1.
- Backpressure: when out_ready drops, one extra entry is absorbed into the skid. in_ready falls the cycle after the skid fills, and rises the cycle after the skid drains.
- Reset mid-transfer drops all entries; there is no partial state.
- Flush together with consume: the consumed entry counts as delivered in that cycle, and the stage is empty next cycle.

## Structure
- Shared package core_pkg:
  - localparams DATA_W=32, DEST_W=4.
  - typedef mem_wb_payload_t (packed struct of the five payload fields).
- Sub-module skid_buffer, parametrised on payload width PAYLOAD_W:
  - Holds the valid/ready, skid and flush logic.
  - mem_wb_skid_reg packs and unpacks the payload, gates wb_en/mem_r_en, and builds wb_value.

## Test plan
- Reset mid-stream with occupancy=2 → all outputs 0, occupancy=0, in_ready=1 within the same cycle (asynchronous).
- Stream 8 entries (dest=0..7, alu_result=0x100+i, mem_r_en=i[0]) with out_ready=1 → each appears one cycle after accept, in order. wb_value alternates between alu_result and mem_read_value.
- out_ready=0 while sending A (dest=3), B (dest=5), C → A held on outputs, B in skid, in_ready=0, C not accepted, occupancy=2. Then out_ready=1 → A, B, C delivered in order.
- Occupancy=2, assert flush with in_valid=1 → next cycle out_valid=0, wb_en=0, occupancy=0, and the flushed input never appears.
- Load entry (mem_r_en=1, mem_read_value=0xDEADBEEF, alu_result=0x1000) → wb_value=0xDEADBEEF. Entry with wb_en_in=1 but in_valid=0 → wb_en output stays 0.
- DATA_W=64, DEST_W=5 instance → full 64-bit values and dest=31 pass unchanged.
